// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, bus widths and the
// owner tag carried alongside each accepted access.
package fb_pkg;

   localparam int unsigned PANEL_W     = 320;
   localparam int unsigned PANEL_H     = 240;
   localparam int unsigned PX_PER_BYTE = 8;

   // Mono panel, one bit per pixel.
   localparam int unsigned FBSIZE = PANEL_W * PANEL_H / PX_PER_BYTE;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_LCD  = 2'd1,
      OWN_HOST = 2'd2
   } owner_e;

   typedef struct packed {
      owner_e owner;
      logic   we;
      logic   err;
   } tag_t;

   localparam tag_t TAG_NONE = '{
      owner: OWN_NONE,
      we:    1'b0,
      err:   1'b0
   };

   function automatic logic out_of_range(
      input logic [ADDR_W-1:0] addr,
      input int unsigned       size
   );
      return addr >= ADDR_W'(size);
   endfunction

endpackage

// File: rtl/fb_rsp_pipe.sv
// fb_rsp_pipe: two-stage owner tag pipe that lines up with
// the RAM read latency and steers read data to its owner.
module fb_rsp_pipe (
   input  logic                      clk,
   input  logic                      rst_n,
   input  fb_pkg::tag_t              acc_tag,
   input  logic [fb_pkg::DATA_W-1:0] ram_rdata,
   output logic                      lcd_rvalid,
   output logic [fb_pkg::DATA_W-1:0] lcd_rdata,
   output logic                      host_rvalid,
   output logic [fb_pkg::DATA_W-1:0] host_rdata,
   output logic                      host_err
);
   import fb_pkg::*;

   tag_t              s1_q, s1_d;
   tag_t              s2_q, s2_d;
   logic              lcd_rvalid_q, lcd_rvalid_d;
   logic [DATA_W-1:0] lcd_rdata_q, lcd_rdata_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
   logic              host_err_q, host_err_d;
   logic [DATA_W-1:0] rsp_data;

   // Advance tags in order; stage 2 meets the RAM data.
   always_comb begin
      s1_d = acc_tag;
      s2_d = s1_q;
   end

   // Route the returning byte; out-of-range reads return zero.
   always_comb begin
      rsp_data      = s2_q.err ? '0 : ram_rdata;
      lcd_rvalid_d  = 1'b0;
      lcd_rdata_d   = lcd_rdata_q;
      host_rvalid_d = 1'b0;
      host_rdata_d  = host_rdata_q;
      host_err_d    = 1'b0;
      unique case (s2_q.owner)
         OWN_LCD: begin
            lcd_rvalid_d = 1'b1;
            lcd_rdata_d  = rsp_data;
         end
         OWN_HOST: begin
            host_err_d = s2_q.err;
            if (!s2_q.we) begin
               host_rvalid_d = 1'b1;
               host_rdata_d  = rsp_data;
            end
         end
         default: ;
      endcase
   end

   // Pipe and response registers; reset drops in-flight tags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q          <= TAG_NONE;
         s2_q          <= TAG_NONE;
         lcd_rvalid_q  <= 1'b0;
         lcd_rdata_q   <= '0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
         host_err_q    <= 1'b0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         lcd_rvalid_q  <= lcd_rvalid_d;
         lcd_rdata_q   <= lcd_rdata_d;
         host_rvalid_q <= host_rvalid_d;
         host_rdata_q  <= host_rdata_d;
         host_err_q    <= host_err_d;
      end
   end

   assign lcd_rvalid  = lcd_rvalid_q;
   assign lcd_rdata   = lcd_rdata_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;
   assign host_err    = host_err_q;

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one framebuffer RAM port between LCD
// scanout and the host, with bounded host starvation.
module fb_arbiter #(
   parameter int unsigned FBSIZE     = fb_pkg::FBSIZE,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      lcd_req,
   input  logic [fb_pkg::ADDR_W-1:0] lcd_addr,
   output logic                      lcd_rdy,
   output logic                      lcd_rvalid,
   output logic [fb_pkg::DATA_W-1:0] lcd_rdata,
   input  logic                      host_req,
   input  logic                      host_we,
   input  logic [fb_pkg::ADDR_W-1:0] host_addr,
   input  logic [fb_pkg::DATA_W-1:0] host_wdata,
   output logic                      host_rdy,
   output logic                      host_rvalid,
   output logic [fb_pkg::DATA_W-1:0] host_rdata,
   output logic                      host_err,
   output logic [fb_pkg::ADDR_W-1:0] ram_addr,
   output logic                      ram_we,
   output logic [fb_pkg::DATA_W-1:0] ram_wdata,
   input  logic [fb_pkg::DATA_W-1:0] ram_rdata
);
   import fb_pkg::*;

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

   logic host_turn;
   logic lcd_go;
   logic host_go;
   logic lcd_oor;
   logic host_oor;
   tag_t acc_tag;

   // Grant: LCD by default, host once it has been starved enough.
   always_comb begin
      host_turn = (starve_q == CNT_MAX);
      lcd_go    = rst_n & lcd_req & (~host_req | ~host_turn);
      host_go   = rst_n & host_req & (~lcd_req | host_turn);
   end

   assign lcd_rdy  = lcd_go;
   assign host_rdy = host_go;

   // Launch the winner onto the RAM port and build its tag.
   always_comb begin
      lcd_oor     = out_of_range(lcd_addr, FBSIZE);
      host_oor    = out_of_range(host_addr, FBSIZE);
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      acc_tag     = TAG_NONE;
      unique case (1'b1)
         lcd_go: begin
            ram_addr_d    = lcd_addr;
            acc_tag.owner = OWN_LCD;
            acc_tag.err   = lcd_oor;
         end
         host_go: begin
            ram_addr_d    = host_addr;
            ram_we_d      = host_we & ~host_oor;
            ram_wdata_d   = host_wdata;
            acc_tag.owner = OWN_HOST;
            acc_tag.we    = host_we;
            acc_tag.err   = host_oor;
         end
         default: ;
      endcase
   end

   // Count LCD wins while the host waits; saturate at the limit.
   always_comb begin
      starve_d = starve_q;
      if (!host_req || host_go) begin
         starve_d = '0;
      end else if (lcd_go && !host_turn) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // RAM port and starvation registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q    <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         starve_q    <= starve_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign ram_addr  = ram_addr_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;

   fb_rsp_pipe u_rsp (
      .clk         (clk),
      .rst_n       (rst_n),
      .acc_tag     (acc_tag),
      .ram_rdata   (ram_rdata),
      .lcd_rvalid  (lcd_rvalid),
      .lcd_rdata   (lcd_rdata),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .host_err    (host_err)
   );

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed and randomized checks of fb_arbiter
// against a transaction-level framebuffer model.
module tb_fb_arbiter;

   localparam int FBSIZE     = 9600;
   localparam int STARVE_MAX = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lcd_req;
   logic [31:0] lcd_addr;
   logic        lcd_rdy;
   logic        lcd_rvalid;
   logic [7:0]  lcd_rdata;
   logic        host_req;
   logic        host_we;
   logic [31:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_rdy;
   logic        host_rvalid;
   logic [7:0]  host_rdata;
   logic        host_err;
   logic [31:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   fb_arbiter #(
      .FBSIZE     (FBSIZE),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lcd_req     (lcd_req),
      .lcd_addr    (lcd_addr),
      .lcd_rdy     (lcd_rdy),
      .lcd_rvalid  (lcd_rvalid),
      .lcd_rdata   (lcd_rdata),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdy    (host_rdy),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .host_err    (host_err),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous framebuffer RAM; out-of-range reads give junk.
   logic [7:0] mem [0:FBSIZE-1];
   always @(posedge clk) begin
      if (ram_addr < 32'(FBSIZE)) begin
         if (ram_we) mem[ram_addr[13:0]] <= ram_wdata;
         ram_rdata <= mem[ram_addr[13:0]];
      end else begin
         ram_rdata <= 8'hEE;
      end
   end

   typedef struct packed {
      logic       lv;
      logic [7:0] ld;
      logic       hv;
      logic [7:0] hd;
      logic       he;
   } rsp_t;

   logic [7:0]  ref_mem [0:FBSIZE-1];
   rsp_t        pend[$];
   int          m_starve;
   logic [31:0] m_addr;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        obs_lrdy;
   logic        obs_hrdy;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      pend.push_back('0);
      pend.push_back('0);
      m_starve = 0;
      m_addr   = '0;
   endtask

   // One cycle: drive at negedge, predict grant and response,
   // check the RAM port and the response due this edge.
   task automatic step(input logic lr, input logic [31:0] la,
                       input logic hr, input logic hw,
                       input logic [31:0] ha, input logic [7:0] hd,
                       output logic lacc, output logic hacc);
      rsp_t r;
      rsp_t e;
      logic lwin, hwin, lo, ho, exp_we;
      lcd_req    = lr;
      lcd_addr   = la;
      host_req   = hr;
      host_we    = hw;
      host_addr  = ha;
      host_wdata = hd;
      #1;
      obs_lrdy = lcd_rdy;
      obs_hrdy = host_rdy;
      lwin = lr && (!hr || m_starve != STARVE_MAX);
      hwin = hr && !lwin;
      chk("lcd_rdy", {31'b0, lcd_rdy}, {31'b0, lwin});
      chk("host_rdy", {31'b0, host_rdy}, {31'b0, hwin});
      lo = la >= FBSIZE;
      ho = ha >= FBSIZE;
      r = '0;
      exp_we = 1'b0;
      if (lwin) begin
         r.lv   = 1'b1;
         r.ld   = lo ? 8'h00 : ref_mem[la[13:0]];
         m_addr = la;
      end
      if (hwin) begin
         m_addr = ha;
         r.he   = ho;
         if (hw) begin
            exp_we = !ho;
            if (!ho) ref_mem[ha[13:0]] = hd;
         end else begin
            r.hv = 1'b1;
            r.hd = ho ? 8'h00 : ref_mem[ha[13:0]];
         end
      end
      if (!hr || hwin) m_starve = 0;
      else if (lwin && m_starve < STARVE_MAX) m_starve++;
      pend.push_back(r);
      e = pend.pop_front();
      lacc = lwin;
      hacc = hwin;
      @(posedge clk);
      @(negedge clk);
      chk("ram_we", {31'b0, ram_we}, {31'b0, exp_we});
      chk("ram_addr", ram_addr, m_addr);
      if (exp_we) chk("ram_wdata", {24'b0, ram_wdata}, {24'b0, hd});
      chk("lcd_rvalid", {31'b0, lcd_rvalid}, {31'b0, e.lv});
      chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, e.hv});
      chk("host_err", {31'b0, host_err}, {31'b0, e.he});
      if (e.lv) chk("lcd_rdata", {24'b0, lcd_rdata}, {24'b0, e.ld});
      if (e.hv) chk("host_rdata", {24'b0, host_rdata}, {24'b0, e.hd});
   endtask

   task automatic idle(input int n);
      logic a, b;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a, b);
   endtask

   task automatic chk_reset_vals();
      chk("rst_lcd_rvalid", {31'b0, lcd_rvalid}, 32'd0);
      chk("rst_lcd_rdata", {24'b0, lcd_rdata}, 32'd0);
      chk("rst_host_rvalid", {31'b0, host_rvalid}, 32'd0);
      chk("rst_host_rdata", {24'b0, host_rdata}, 32'd0);
      chk("rst_host_err", {31'b0, host_err}, 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
      chk("rst_ram_wdata", {24'b0, ram_wdata}, 32'd0);
      chk("rst_lcd_rdy", {31'b0, lcd_rdy}, 32'd0);
      chk("rst_host_rdy", {31'b0, host_rdy}, 32'd0);
   endtask

   initial begin
      logic        la_ok, ha_ok;
      logic        hreq, hwe;
      logic [31:0] haddr;
      logic [7:0]  hdat;
      int          a, nh, nidle;

      for (int i = 0; i < FBSIZE; i++) begin
         mem[i]     = 8'(i + 16);
         ref_mem[i] = 8'(i + 16);
      end
      rst_n      = 1'b0;
      lcd_req    = 1'b1;
      lcd_addr   = 32'd7;
      host_req   = 1'b1;
      host_we    = 1'b0;
      host_addr  = 32'd9;
      host_wdata = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk_reset_vals();
      @(negedge clk);
      lcd_req  = 1'b0;
      host_req = 1'b0;
      rst_n    = 1'b1;
      model_reset();

      // LCD burst 0..3: data 0x10..0x13, latency 2.
      for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0, 0, la_ok, ha_ok);
      idle(3);

      // Write then immediate read-back of the same byte.
      step(0, 0, 1, 1, 100, 8'hA5, la_ok, ha_ok);
      step(0, 0, 1, 0, 100, 8'h00, la_ok, ha_ok);
      idle(3);

      // Out-of-range host write and read.
      step(0, 0, 1, 1, FBSIZE, 8'h5A, la_ok, ha_ok);
      step(0, 0, 1, 0, FBSIZE, 8'h00, la_ok, ha_ok);
      step(1, FBSIZE + 3, 0, 0, 0, 0, la_ok, ha_ok);
      idle(3);

      // Both requesting continuously: one host slot per 9 cycles.
      nh    = 0;
      nidle = 0;
      for (int i = 0; i < 36; i++) begin
         step(1, i, 1, 0, 200, 0, la_ok, ha_ok);
         if (obs_hrdy) nh++;
         if (!obs_hrdy && !obs_lrdy) nidle++;
      end
      chk("host_grants_36", nh, 4);
      chk("idle_cycles_36", nidle, 0);
      idle(3);

      // Reset one cycle after an LCD acceptance.
      step(1, 12, 0, 0, 0, 0, la_ok, ha_ok);
      lcd_req  = 1'b1;
      host_req = 1'b1;
      rst_n    = 1'b0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      #1;
      chk_reset_vals();
      @(negedge clk);
      lcd_req  = 1'b0;
      host_req = 1'b0;
      rst_n    = 1'b1;
      model_reset();
      idle(4);

      // Random mixed traffic.
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(1)), $urandom_range(FBSIZE + 7),
              1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom_range(FBSIZE + 7), 8'($urandom),
              la_ok, ha_ok);
      end
      idle(3);

      // Full scan with random held host traffic.
      a     = 0;
      hreq  = 1'b0;
      hwe   = 1'b0;
      haddr = '0;
      hdat  = '0;
      while (a < FBSIZE) begin
         if (!hreq && $urandom_range(3) == 0) begin
            hreq  = 1'b1;
            hwe   = 1'($urandom_range(1));
            haddr = $urandom_range(FBSIZE + 15);
            hdat  = 8'($urandom);
         end
         step(1, a, hreq, hwe, haddr, hdat, la_ok, ha_ok);
         if (la_ok) a++;
         if (ha_ok) hreq = 1'b0;
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FBSIZE, default 9600 (320x240 mono, 8 px/byte), framebuffer size in bytes; byte addresses >= FBSIZE are out of range.
REQ-002 Parameter STARVE_MAX, default 8, max consecutive LCD acceptances while host_req is held.
REQ-003 clk  in  1  sole clock; the arbiter and framebuffer RAM are both clocked by it.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 lcd_req  in  1  scanout read request, held with lcd_addr until accepted.
REQ-006 lcd_addr  in  32  scanout byte address.
REQ-007 lcd_rdy  out  1  combinational accept; transfer occurs on an edge with lcd_req & lcd_rdy.
REQ-008 lcd_rvalid  out  1  one-cycle pulse: lcd_rdata valid.
REQ-009 lcd_rdata  out  8  read byte.
REQ-010 host_req  in  1  host access request.
REQ-011 host_we  in  1  1 = write, 0 = read.
REQ-012 host_addr  in  32  host byte address.
REQ-013 host_wdata  in  8  write byte.
REQ-014 host_rdy  out  1  combinational accept, same rule as lcd_rdy.
REQ-015 host_rvalid  out  1  one-cycle pulse: host_rdata valid (reads only).
REQ-016 host_rdata  out  8  read byte.
REQ-017 host_err  out  1  one-cycle pulse: out-of-range access completed.
REQ-018 ram_addr  out  32  registered RAM address.
REQ-019 ram_we  out  1  registered RAM write strobe.
REQ-020 ram_wdata  out  8  registered RAM write data.
REQ-021 ram_rdata  in  8  RAM read data, valid one edge after ram_addr is sampled.

Function
REQ-022 At most one acceptance per cycle; back-to-back acceptances every cycle are supported.
REQ-023 Only LCD requesting: lcd_rdy=1; only host requesting: host_rdy=1; neither requesting: both rdy=0.
REQ-024 Both requesting: LCD wins unless starve_cnt == STARVE_MAX, in which case host wins.
REQ-025 starve_cnt: +1 on each LCD acceptance with host_req high; cleared on host acceptance or when host_req is low; saturates at STARVE_MAX.
REQ-026 Acceptance at edge k registers ram_addr/ram_we/ram_wdata at edge k; the RAM samples them at k+1; the response is registered at k+2 (2-cycle latency).
REQ-027 A 2-stage owner tag pipe (NONE/LCD/HOST + read/write + err) routes each response; tags never reorder.
REQ-028 LCD read: lcd_rvalid=1 and lcd_rdata=ram_rdata at k+2.
REQ-029 Host read: host_rvalid=1 and host_rdata=ram_rdata at k+2; host write: RAM written at k+1, no rvalid.
REQ-030 Out of range (addr >= FBSIZE): accepted normally, ram_we forced 0, rdata 0x00; rvalid still pulses for reads; host_err pulses at k+2; LCD out-of-range returns 0x00 with no error output.
REQ-031 Idle cycles drive ram_we=0 and hold ram_addr.
REQ-032 A host read of an address written in the immediately preceding cycle returns the new data (RAM write occurs before read sampling).

Reset
REQ-033 On rst_n low: ram_addr=0, ram_we=0, ram_wdata=0, starve_cnt=0, tag pipe=NONE, all rvalid/err=0, rdata=0.
REQ-034 Reset mid-transfer discards in-flight tags; no rvalid or err pulse appears after deassertion for pre-reset acceptances.
REQ-035 Both rdy outputs are 0 while rst_n is low.

Structure
REQ-036 Shared package fb_pkg holds FBSIZE (derived from the panel fbsize), the owner tag encoding, and address/data widths.
REQ-037 One sub-module fb_rsp_pipe implements the 2-stage tag pipe and response demux; arbitration stays in fb_arbiter.

Verification
REQ-038 LCD reads addrs 0..3 back-to-back, RAM preloaded with 0x10+addr -> lcd_rvalid on 4 consecutive cycles, data 0x10..0x13, first response 2 cycles after first acceptance.
REQ-039 LCD and host request continuously -> exactly 1 host acceptance per 9 cycles (STARVE_MAX=8) and no cycle without an acceptance.
REQ-040 Host write 0xA5 to addr 100, then a host read of 100 next cycle -> host_rdata=0xA5 at latency 2.
REQ-041 Host write to addr 9600 -> ram_we stays 0 and host_err pulses once at k+2; host read of addr 9600 -> host_rvalid with 0x00 and host_err.
REQ-042 Assert rst_n low one cycle after an LCD acceptance -> no lcd_rvalid afterwards; all outputs at reset values.
REQ-043 Full 9600-byte LCD scan interleaved with random host writes -> every LCD byte matches the scoreboard model in order.
